dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
- REQ-001: Clocking SHALL be one clock; reset is asynchronous and active-high.
- REQ-002: clk  input  1  rising-edge clock for all state.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: proc_read  input  1  processor read request, word access.
- REQ-005: proc_write  input  1  processor write request, word access.
- REQ-006: proc_addr  input  30  word address: tag [29:5], index [4:2], word offset [1:0].
- REQ-007: proc_wdata  input  32  store data.
- REQ-008: proc_stall  output  1  high while the current request cannot complete this cycle.
- REQ-009: proc_rdata  output  32  load data, valid when proc_read=1 and proc_stall=0.
- REQ-010: mem_read  output  1  block read request to memory.
- REQ-011: mem_write  output  1  block write request to memory.
- REQ-012: mem_addr  output  28  block address (word address [29:2]).
- REQ-013: mem_wdata  output  128  write-back block, word 0 in bits [31:0].
- REQ-014: mem_rdata  input  128  fill block, same word order.
- REQ-015: mem_ready  input  1  one-cycle pulse completing the pending mem_read or mem_write; latency arbitrary (>=1 cycle).

Function
- REQ-016: Organization SHALL be direct-mapped, 8 lines x 4 words, write-back, write-allocate; each line holds valid, dirty and a 25-bit tag.
- REQ-017: Hit SHALL be valid[index] and tag[index]==proc_addr[29:5], evaluated combinationally.
- REQ-018: FSM states SHALL be COMPARE, WRITEBACK, ALLOCATE; reset state COMPARE.
- REQ-019: COMPARE with no request: proc_stall=0, mem_read=0, mem_write=0.
- REQ-020: COMPARE read hit: proc_stall=0 same cycle; proc_rdata = line word at offset, zero added latency.
- REQ-021: COMPARE write hit: proc_stall=0; word written and dirty set at the next rising edge; other words untouched.
- REQ-022: COMPARE miss, victim clean or invalid: proc_stall=1; next state ALLOCATE.
- REQ-023: COMPARE miss, victim valid and dirty: proc_stall=1; next state WRITEBACK.
- REQ-024: WRITEBACK: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line, held stable; on mem_ready go to ALLOCATE.
- REQ-025: ALLOCATE: mem_read=1, mem_addr=proc_addr[29:2]; on mem_ready load mem_rdata into the line, set valid, clear dirty, write tag, go to COMPARE.
- REQ-026: After a fill, the retried access SHALL hit in COMPARE one cycle later; a write then sets dirty.
- REQ-027: proc_stall SHALL stay 1 in WRITEBACK and ALLOCATE, including the mem_ready cycle.
- REQ-028: mem_read and mem_write SHALL never be high simultaneously; both SHALL be 0 in COMPARE.
- REQ-029: The processor holds proc_addr, proc_read, proc_write and proc_wdata stable while proc_stall=1; the block SHALL NOT sample them only once.
- REQ-030: proc_read and proc_write both high SHALL be treated as a write.
- REQ-031: mem_ready outside WRITEBACK/ALLOCATE SHALL be ignored.

Reset
- REQ-032: Reset SHALL clear all valid and dirty bits and force COMPARE immediately, including mid-WRITEBACK or mid-ALLOCATE.
- REQ-033: During reset, mem_read=0, mem_write=0 and proc_stall=0; tag and data arrays need no reset.
- REQ-034: The first request after reset SHALL miss.

Verification
- REQ-035: Cold read: reset, read 0x0000010 -> stall; mem_read=1, mem_addr=0x0000004; mem_ready with word0=0xA5A5A5A5 -> one cycle later stall=0, rdata=0xA5A5A5A5.
- REQ-036: Write hit: after REQ-035, write 0x0000011 data 0x12345678 -> stall=0; the next read of 0x0000011 returns 0x12345678 with no memory traffic.
- REQ-037: Dirty eviction: after REQ-036, read 0x0000090 (same index, new tag) -> mem_write=1, mem_addr=0x0000004, mem_wdata[63:32]=0x12345678; after mem_ready, mem_read=1, mem_addr=0x0000024.
- REQ-038: Variable latency: delay mem_ready 1, 5 and 20 cycles -> stall held throughout, and mem_addr and mem_wdata are constant.
- REQ-039: Reset mid-ALLOCATE: assert rst while mem_read=1 -> mem_read=0 asynchronously; reading the same address afterwards misses again.
- REQ-040: Protocol checker, all tests: never mem_read&&mem_write; proc_stall=0 whenever state=COMPARE and hit or no request.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// Processor and memory bus of the direct-mapped data cache.
// The cache is the slave; the processor/memory environment is the master.
interface dcache_ctrl_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache: 8 lines x 4 words.
// Hits complete with no added latency; misses write back a dirty victim, then fill.
module dcache_ctrl (
  input  logic         clk,
  input  logic         rst,
  dcache_ctrl_if.slave bus
);

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t       r_state;
  logic [7:0]   r_valid;
  logic [7:0]   r_dirty;
  logic [24:0]  r_tag  [8];
  logic [127:0] r_data [8];
  logic         r_mem_read;
  logic         r_mem_write;
  logic [27:0]  r_mem_addr;
  logic [127:0] r_mem_wdata;

  logic [24:0]  w_tag;
  logic [2:0]   w_index;
  logic [1:0]   w_off;
  logic         w_req;
  logic         w_hit;
  logic         w_wr_hit;
  logic         w_fill;

  assign w_tag    = bus.proc_addr[29:5];
  assign w_index  = bus.proc_addr[4:2];
  assign w_off    = bus.proc_addr[1:0];
  assign w_req    = bus.proc_read | bus.proc_write;
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  // A simultaneous read+write is a write; the read data is simply ignored.
  assign w_wr_hit = (r_state == COMPARE) && bus.proc_write && w_hit;
  assign w_fill   = (r_state == ALLOCATE) && bus.mem_ready;

  assign bus.proc_stall = !rst && ((r_state != COMPARE) || (w_req && !w_hit));
  assign bus.proc_rdata = r_data[w_index][{w_off, 5'd0} +: 32];
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

  // Memory request outputs are registered so they stay stable while waiting on mem_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= COMPARE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        COMPARE: begin
          if (w_req && !w_hit) begin
            if (r_valid[w_index] && r_dirty[w_index]) begin
              r_state     <= WRITEBACK;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {r_tag[w_index], w_index};
              r_mem_wdata <= r_data[w_index];
            end else begin
              r_state    <= ALLOCATE;
              r_mem_read <= 1'b1;
              r_mem_addr <= bus.proc_addr[29:2];
            end
          end else if (w_wr_hit) begin
            r_dirty[w_index] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (bus.mem_ready) begin
            r_state     <= ALLOCATE;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_addr  <= bus.proc_addr[29:2];
          end
        end
        ALLOCATE: begin
          if (bus.mem_ready) begin
            r_state          <= COMPARE;
            r_mem_read       <= 1'b0;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
          end
        end
        default: r_state <= COMPARE;
      endcase
    end
  end

  // NOTE: tag/data arrays carry no reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_index] <= bus.mem_rdata;
      r_tag[w_index]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_index][{w_off, 5'd0} +: 32] <= bus.proc_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed accesses push expected memory requests
// and load data; a monitor pops and compares whenever the DUT presents them.
module tb_dcache_ctrl;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   lat      = 1;

  mem_exp_t     mem_q [$];
  logic [31:0]  rd_q  [$];
  logic [127:0] mem_blk [logic [27:0]];

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: event not as required", name);
  endtask

  function automatic logic [127:0] get_blk(input logic [27:0] a);
    logic [127:0] r;
    if (mem_blk.exists(a)) return mem_blk[a];
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = {4'hC, a[23:0], 4'(w)};
    return r;
  endfunction

  task automatic push_mem(input bit wr, input logic [27:0] a, input logic [127:0] d);
    mem_exp_t e;
    e.wr = wr; e.addr = a; e.wdata = d;
    mem_q.push_back(e);
  endtask

  // One processor access held until the cache stops stalling; checks the stall length.
  task automatic access(input bit rd, input bit wr, input logic [29:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input int exp_stall);
    int n = 0;
    @(posedge clk); #2;
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = a;
    bus.proc_wdata = d;
    if (rd && !wr) rd_q.push_back(exp_rdata);
    forever begin
      @(negedge clk);
      if (!bus.proc_stall) break;
      n++;
      if (n > 500) begin
        fail_now("access_timeout");
        break;
      end
    end
    check("stall_cycles", n, exp_stall);
    @(posedge clk); #2;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  // Memory model: answers each request after lat cycles; abandons it on reset.
  initial begin
    bit aborted;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (!rst && (bus.mem_read || bus.mem_write)) begin
        aborted = 1'b0;
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          if (bus.mem_write) mem_blk[bus.mem_addr] = bus.mem_wdata;
          else               bus.mem_rdata = get_blk(bus.mem_addr);
          bus.mem_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: protocol rules every cycle, scoreboard pops on memory requests and load completions.
  initial begin
    bit           prev_rd = 1'b0;
    bit           prev_wr = 1'b0;
    logic [27:0]  h_addr  = '0;
    logic [127:0] h_wdata = '0;
    mem_exp_t     e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("no_rd_wr_overlap", bus.mem_read && bus.mem_write, 1'b0);
        if (!bus.proc_read && !bus.proc_write) check("idle_no_stall", bus.proc_stall, 1'b0);
        if ((bus.mem_read && !prev_rd) || (bus.mem_write && !prev_wr)) begin
          if (mem_q.size() == 0) fail_now("unexpected_mem_req");
          else begin
            e = mem_q.pop_front();
            check("mem_req_is_write", bus.mem_write, e.wr);
            check("mem_addr", bus.mem_addr, e.addr);
            if (e.wr) check("mem_wdata", bus.mem_wdata, e.wdata);
          end
          check("stall_in_mem_req", bus.proc_stall, 1'b1);
          h_addr  = bus.mem_addr;
          h_wdata = bus.mem_wdata;
        end else if (bus.mem_read || bus.mem_write) begin
          check("mem_addr_stable", bus.mem_addr, h_addr);
          if (bus.mem_write) check("mem_wdata_stable", bus.mem_wdata, h_wdata);
          check("stall_in_mem_req", bus.proc_stall, 1'b1);
        end
        if (bus.proc_read && !bus.proc_write && !bus.proc_stall) begin
          if (rd_q.size() == 0) fail_now("unexpected_read_done");
          else check("proc_rdata", bus.proc_rdata, rd_q.pop_front());
        end
      end
      prev_rd = bus.mem_read;
      prev_wr = bus.mem_write;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    mem_blk[28'h4] = {32'h44440003, 32'h44440002, 32'h44440001, 32'hA5A5A5A5};
    bus.proc_read  = 1'b1;
    bus.proc_write = 1'b0;
    bus.proc_addr  = 30'h10;
    bus.proc_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", bus.proc_stall, 1'b0);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    bus.proc_read = 1'b0;
    @(posedge clk); #2 rst = 1'b0;

    // Cold read miss, then write hit and hits on the same line
    lat = 5;
    push_mem(1'b0, 28'h4, '0);
    access(1, 0, 30'h10, 0, 32'hA5A5A5A5, 6);
    access(0, 1, 30'h11, 32'h12345678, 0, 0);
    access(1, 0, 30'h11, 0, 32'h12345678, 0);
    access(1, 0, 30'h10, 0, 32'hA5A5A5A5, 0);
    access(1, 0, 30'h12, 0, 32'h44440002, 0);

    // Dirty eviction with long latency, then clean miss with shortest latency
    lat = 20;
    push_mem(1'b1, 28'h4, {32'h44440003, 32'h44440002, 32'h12345678, 32'hA5A5A5A5});
    push_mem(1'b0, 28'h24, '0);
    access(1, 0, 30'h90, 0, 32'hC0000240, 41);
    lat = 1;
    push_mem(1'b0, 28'h4, '0);
    access(1, 0, 30'h13, 0, 32'h44440003, 2);
    access(1, 0, 30'h11, 0, 32'h12345678, 0);

    // Read+write together acts as a write; stray mem_ready in COMPARE changes nothing
    access(1, 1, 30'h11, 32'hDEADBEEF, 0, 0);
    @(negedge clk); #1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = '1;
    @(posedge clk); #1 bus.mem_ready = 1'b0;
    access(1, 0, 30'h11, 0, 32'hDEADBEEF, 0);

    lat = 5;
    push_mem(1'b1, 28'h4, {32'h44440003, 32'h44440002, 32'hDEADBEEF, 32'hA5A5A5A5});
    push_mem(1'b0, 28'h24, '0);
    access(1, 0, 30'h91, 0, 32'hC0000241, 11);

    // Write miss allocates, then the retried write lands
    push_mem(1'b0, 28'h2, '0);
    access(0, 1, 30'h08, 32'h0BADF00D, 0, 6);
    access(1, 0, 30'h08, 0, 32'h0BADF00D, 0);
    access(1, 0, 30'h09, 0, 32'hC0000021, 0);

    // Reset in the middle of a fill
    lat = 50;
    push_mem(1'b0, 28'h10, '0);
    @(posedge clk); #2;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h40;
    n = 0;
    while (!bus.mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mem_read_before_rst", bus.mem_read, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_mem_read", bus.mem_read, 1'b0);
    check("rst_async_mem_write", bus.mem_write, 1'b0);
    check("rst_async_stall", bus.proc_stall, 1'b0);
    bus.proc_read = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;

    lat = 3;
    push_mem(1'b0, 28'h10, '0);
    access(1, 0, 30'h40, 0, 32'hC0000100, 4);
    push_mem(1'b0, 28'h2, '0);
    access(1, 0, 30'h08, 0, 32'hC0000020, 4);
    push_mem(1'b0, 28'h4, '0);
    access(1, 0, 30'h10, 0, 32'hA5A5A5A5, 4);

    repeat (5) @(negedge clk);
    check("mem_q_drained", mem_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
